poseidon_stream_checker: RTL

- Synthesizable, parametrised response checker for Poseidon-style hash cores with valid/ready/last streams.
- Sits beside the DUT in emulation and simulation benches:
  - snoops the DUT input-stream handshakes to timestamp each message;
  - drives the DUT output ready;
  - compares each result against an expected-value queue;
  - reports pass/fail, error count, total cycles and worst-case latency.
- Generalises the hard-coded 3-case, always-ready checker to any width, case count and queue depth, and adds latency measurement and a timeout.

---
 rtl/poseidon_tb_pkg.sv | 28 ++
 rtl/sync_fifo.sv | 84 ++++++++
 rtl/poseidon_stream_checker.sv | 274 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/poseidon_tb_pkg.sv
// Shared definitions for the Poseidon stream checker.
//
// Contents:
//   chk_state_e     - checker FSM states (idle, running, finished)
//   DATA_W_DEFAULT  - default field-element width
//   STATE_SIZE      - Poseidon state size (number of field elements)
//   LFSR_SEED/TAPS  - 16-bit Galois LFSR used for output back-pressure
//   lfsr_next()     - one LFSR step
package poseidon_tb_pkg;

    typedef enum logic [1:0] {
        StIdle,
        StRun,
        StDone
    } chk_state_e;

    localparam int unsigned DATA_W_DEFAULT = 255;
    localparam int unsigned STATE_SIZE     = 9;

    // x^16 + x^14 + x^13 + x^11, right-shifting Galois form.
    localparam logic [15:0] LFSR_SEED = 16'hACE1;
    localparam logic [15:0] LFSR_TAPS = 16'hB400;

    function automatic logic [15:0] lfsr_next(input logic [15:0] cur);
        lfsr_next = (cur >> 1) ^ (cur[0] ? LFSR_TAPS : 16'h0000);
    endfunction

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO with full/empty flags.
//
// Parameters:
//   WIDTH - entry width
//   DEPTH - number of entries (power of 2, at least 2)
// Ports:
//   clk, resetn  - clock, synchronous active-low reset (empties the FIFO)
//   flush_i      - empties the FIFO; any push in the same cycle is dropped
//   push_i       - write wdata_i; accepted when not full, or when full and popping
//   pop_i        - drop the head entry; ignored when empty
//   rdata_o      - head entry (valid when !empty_o)
//   full_o       - DEPTH entries held
//   empty_o      - no entries held
module sync_fifo #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned DEPTH = 4
) (
    input  logic             clk,
    input  logic             resetn,
    input  logic             flush_i,
    input  logic             push_i,
    input  logic [WIDTH-1:0] wdata_i,
    input  logic             pop_i,
    output logic [WIDTH-1:0] rdata_o,
    output logic             full_o,
    output logic             empty_o
);

    localparam int unsigned PtrW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CntW = $clog2(DEPTH + 1);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PtrW-1:0]  wr_ptr_q, wr_ptr_d;
    logic [PtrW-1:0]  rd_ptr_q, rd_ptr_d;
    logic [CntW-1:0]  count_q, count_d;
    logic             do_push;
    logic             do_pop;

    assign full_o  = (count_q == CntW'(DEPTH));
    assign empty_o = (count_q == '0);
    assign do_pop  = pop_i & ~empty_o;
    // A pop frees the slot this cycle, so a full FIFO can still take a push.
    assign do_push = push_i & (~full_o | do_pop);
    assign rdata_o = mem_q[rd_ptr_q];

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (flush_i) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (do_push) begin
                wr_ptr_d = wr_ptr_q + 1'b1;
            end
            if (do_pop) begin
                rd_ptr_d = rd_ptr_q + 1'b1;
            end
            count_d = count_q + CntW'(do_push) - CntW'(do_pop);
        end
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage carries no reset; occupancy is tracked by count_q alone.
    always_ff @(posedge clk) begin
        if (do_push && !flush_i) begin
            mem_q[wr_ptr_q] <= wdata_i;
        end
    end

endmodule

// File: rtl/poseidon_stream_checker.sv
// Response checker for Poseidon-style hash cores with valid/ready/last streams.
//
// Snoops the DUT input stream to timestamp each message (on last), drives the
// DUT output ready, compares each result with a preloaded expected-value queue
// and reports pass/fail, error count, cycles spent running and worst latency.
//
// Optional build macro: CHECKER_BACKPRESSURE_EN
//   defined   - dut_out_ready follows bit 0 of a free-running LFSR while running
//   undefined - dut_out_ready is held high while running
//
// Ports:
//   clk, resetn         - clock, synchronous active-low reset
//   start               - pulse: begin a run (from idle or finished)
//   exp_valid/ready/data- expected-result push stream (preload allowed any time)
//   mon_valid/ready/last- snooped DUT input handshake
//   dut_out_valid/ready/data - DUT result stream
//   done, pass, timeout - run status (pass meaningful when done)
//   err_count           - mismatches, underflows and dropped timestamps
//   res_count           - results checked this run
//   cycle_count         - cycles spent running
//   max_latency         - worst last-in to result-out latency in cycles
//   err_valid/err_data  - one-cycle error pulse with the offending payload
module poseidon_stream_checker
    import poseidon_tb_pkg::*;
#(
    parameter int unsigned DATA_W      = DATA_W_DEFAULT,
    parameter int unsigned CASE_NUM    = 3,
    parameter int unsigned EXP_DEPTH   = 4,
    parameter int unsigned TIMEOUT     = 4096,
    parameter bit          STOP_ON_ERR = 1'b1,
    parameter int unsigned CYC_W       = 50
) (
    input  logic                          clk,
    input  logic                          resetn,
    input  logic                          start,
    input  logic                          exp_valid,
    output logic                          exp_ready,
    input  logic [DATA_W-1:0]             exp_data,
    input  logic                          mon_valid,
    input  logic                          mon_ready,
    input  logic                          mon_last,
    input  logic                          dut_out_valid,
    output logic                          dut_out_ready,
    input  logic [DATA_W-1:0]             dut_out_data,
    output logic                          done,
    output logic                          pass,
    output logic                          timeout,
    output logic [15:0]                   err_count,
    output logic [$clog2(CASE_NUM+1)-1:0] res_count,
    output logic [CYC_W-1:0]              cycle_count,
    output logic [CYC_W-1:0]              max_latency,
    output logic                          err_valid,
    output logic [DATA_W-1:0]             err_data
);

    localparam int unsigned ResW  = $clog2(CASE_NUM + 1);
    localparam int unsigned IdleW = $clog2(TIMEOUT + 1);

    chk_state_e        state_q, state_d;
    logic              done_q, done_d;
    logic              pass_q, pass_d;
    logic              timeout_q, timeout_d;
    logic [15:0]       err_count_q, err_count_d;
    logic [ResW-1:0]   res_count_q, res_count_d;
    logic [CYC_W-1:0]  cycle_count_q, cycle_count_d;
    logic [CYC_W-1:0]  max_latency_q, max_latency_d;
    logic              err_valid_q, err_valid_d;
    logic [DATA_W-1:0] err_data_q, err_data_d;
    logic [IdleW-1:0]  idle_q, idle_d;

    logic              run;
    logic              out_hs;
    logic              mon_hs;
    logic              exp_push, exp_pop, exp_full, exp_empty;
    logic [DATA_W-1:0] exp_head;
    logic              ts_pop, ts_full, ts_empty, ts_flush;
    logic [CYC_W-1:0]  ts_head;
    logic [CYC_W-1:0]  latency;
    logic              mismatch, underflow, out_err, ts_drop;
    logic [1:0]        n_err;
    logic [16:0]       err_sum;

    assign run = (state_q == StRun);

`ifdef CHECKER_BACKPRESSURE_EN
    logic [15:0] lfsr_q, lfsr_d;

    always_comb begin
        lfsr_d = lfsr_q;
        if (run) begin
            lfsr_d = lfsr_next(lfsr_q);
        end
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            lfsr_q <= LFSR_SEED;
        end else begin
            lfsr_q <= lfsr_d;
        end
    end

    assign dut_out_ready = resetn & run & lfsr_q[0];
`else
    assign dut_out_ready = resetn & run;
`endif

    assign out_hs   = dut_out_valid & dut_out_ready;
    assign mon_hs   = run & mon_valid & mon_ready & mon_last;
    assign exp_pop  = out_hs & ~exp_empty;
    assign ts_pop   = out_hs & ~ts_empty;
    // Ready stays high on a full FIFO when a result pops the head this cycle.
    assign exp_ready = resetn & (~exp_full | exp_pop);
    assign exp_push  = exp_valid & exp_ready;

    assign mismatch  = exp_pop & (dut_out_data != exp_head);
    assign underflow = out_hs & exp_empty;
    assign out_err   = mismatch | underflow;
    assign ts_drop   = mon_hs & ts_full & ~ts_pop;
    assign n_err     = {1'b0, out_err} + {1'b0, ts_drop};
    assign err_sum   = {1'b0, err_count_q} + 17'(n_err);
    assign latency   = cycle_count_q - ts_head;

    sync_fifo #(
        .WIDTH(DATA_W),
        .DEPTH(EXP_DEPTH)
    ) u_exp_fifo (
        .clk    (clk),
        .resetn (resetn),
        .flush_i(1'b0),
        .push_i (exp_push),
        .wdata_i(exp_data),
        .pop_i  (exp_pop),
        .rdata_o(exp_head),
        .full_o (exp_full),
        .empty_o(exp_empty)
    );

    sync_fifo #(
        .WIDTH(CYC_W),
        .DEPTH(EXP_DEPTH)
    ) u_ts_fifo (
        .clk    (clk),
        .resetn (resetn),
        .flush_i(ts_flush),
        .push_i (mon_hs),
        .wdata_i(cycle_count_q),
        .pop_i  (ts_pop),
        .rdata_o(ts_head),
        .full_o (ts_full),
        .empty_o(ts_empty)
    );

    always_comb begin
        state_d       = state_q;
        done_d        = done_q;
        pass_d        = pass_q;
        timeout_d     = timeout_q;
        err_count_d   = err_count_q;
        res_count_d   = res_count_q;
        cycle_count_d = cycle_count_q;
        max_latency_d = max_latency_q;
        err_valid_d   = 1'b0;
        err_data_d    = err_data_q;
        idle_d        = idle_q;
        ts_flush      = 1'b0;

        case (state_q)
            StIdle, StDone: begin
                // The expected FIFO is kept so it can be preloaded before start.
                if (start) begin
                    state_d       = StRun;
                    done_d        = 1'b0;
                    pass_d        = 1'b0;
                    timeout_d     = 1'b0;
                    err_count_d   = '0;
                    res_count_d   = '0;
                    cycle_count_d = '0;
                    max_latency_d = '0;
                    err_data_d    = '0;
                    idle_d        = '0;
                    ts_flush      = 1'b1;
                end
            end

            StRun: begin
                if (cycle_count_q != {CYC_W{1'b1}}) begin
                    cycle_count_d = cycle_count_q + 1'b1;
                end

                // Idle time only matters while a message is awaiting its result.
                if (out_hs) begin
                    idle_d = '0;
                end else if (!ts_empty && idle_q != {IdleW{1'b1}}) begin
                    idle_d = idle_q + 1'b1;
                end

                err_count_d = err_sum[16] ? 16'hFFFF : err_sum[15:0];
                if (n_err != 2'd0) begin
                    err_valid_d = 1'b1;
                end
                if (out_err) begin
                    err_data_d = dut_out_data;
                end

                if (ts_pop && (latency > max_latency_q)) begin
                    max_latency_d = latency;
                end

                if (out_hs && (res_count_q != ResW'(CASE_NUM))) begin
                    res_count_d = res_count_q + 1'b1;
                end

                if (STOP_ON_ERR && (n_err != 2'd0)) begin
                    state_d = StDone;
                    done_d  = 1'b1;
                    pass_d  = 1'b0;
                end else if (res_count_d == ResW'(CASE_NUM)) begin
                    state_d = StDone;
                    done_d  = 1'b1;
                    pass_d  = (err_count_d == 16'd0);
                end else if (idle_d == IdleW'(TIMEOUT)) begin
                    state_d   = StDone;
                    done_d    = 1'b1;
                    pass_d    = 1'b0;
                    timeout_d = 1'b1;
                end
            end

            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            state_q       <= StIdle;
            done_q        <= 1'b0;
            pass_q        <= 1'b0;
            timeout_q     <= 1'b0;
            err_count_q   <= '0;
            res_count_q   <= '0;
            cycle_count_q <= '0;
            max_latency_q <= '0;
            err_valid_q   <= 1'b0;
            err_data_q    <= '0;
            idle_q        <= '0;
        end else begin
            state_q       <= state_d;
            done_q        <= done_d;
            pass_q        <= pass_d;
            timeout_q     <= timeout_d;
            err_count_q   <= err_count_d;
            res_count_q   <= res_count_d;
            cycle_count_q <= cycle_count_d;
            max_latency_q <= max_latency_d;
            err_valid_q   <= err_valid_d;
            err_data_q    <= err_data_d;
            idle_q        <= idle_d;
        end
    end

    assign done        = done_q;
    assign pass        = pass_q;
    assign timeout     = timeout_q;
    assign err_count   = err_count_q;
    assign res_count   = res_count_q;
    assign cycle_count = cycle_count_q;
    assign max_latency = max_latency_q;
    assign err_valid   = err_valid_q;
    assign err_data    = err_data_q;

endmodule
